// File: rtl/darktimer_pkg.sv
// Shared register map, control-bit layout and bus helpers for the darkriscv timer/IRQ block.
package darktimer_pkg;

    localparam int REG_INFO  = 0;
    localparam int REG_PRESC = 1;
    localparam int REG_PEND  = 2;
    localparam int REG_MASK  = 3;

    localparam int CH_BASE   = 4;
    localparam int CH_STRIDE = 4;
    localparam int CH_CTRL   = 0;
    localparam int CH_LOAD   = 1;
    localparam int CH_COUNT  = 2;

    localparam int CTRL_EN       = 0;
    localparam int CTRL_PERIODIC = 1;

    typedef struct packed {
        logic periodic;
        logic en;
    } ctrl_t;

    function automatic logic [31:0] be_merge(input logic [31:0] cur,
                                             input logic [31:0] wdat,
                                             input logic [3:0]  be);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = be[b] ? wdat[8*b +: 8] : cur[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/darktimer_ch.sv
// One timer channel: LOAD/COUNT/CTRL registers and the run/idle sequencer.
//  state | meaning
//  IDLE  | EN=0, COUNT holds its value
//  RUN   | EN=1, COUNT steps down once per prescaler tick, fires at zero
module darktimer_ch
    import darktimer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RES,
    input  logic             tick,
    input  logic             wr_ctrl,
    input  logic             wr_load,
    input  logic             wr_count,
    input  logic [3:0]       BE,
    input  logic [31:0]      DATAI,
    output ctrl_t            ctrl,
    output logic [WIDTH-1:0] load,
    output logic [WIDTH-1:0] count,
    output logic             fire
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             periodic_q, periodic_d;
    logic [WIDTH-1:0] load_q, load_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [31:0]      load_wv, count_wv;
    ctrl_t            ctrl_wv;

    assign ctrl.en       = (state_q == ST_RUN);
    assign ctrl.periodic = periodic_q;
    assign load          = load_q;
    assign count         = count_q;

    assign load_wv  = be_merge(32'(load_q), DATAI, BE);
    assign count_wv = be_merge(32'(count_q), DATAI, BE);

    assign fire = (state_q == ST_RUN) && tick && (count_q == '0);

    always_comb begin
        ctrl_wv.en       = BE[0] ? DATAI[CTRL_EN]       : ctrl.en;
        ctrl_wv.periodic = BE[0] ? DATAI[CTRL_PERIODIC] : ctrl.periodic;
    end

    // Later assignments win: tick < CTRL write < COUNT write. A one-shot expiry
    // is not undone by a CTRL write that merely keeps EN=1.
    always_comb begin
        state_d    = state_q;
        periodic_d = periodic_q;
        load_d     = load_q;
        count_d    = count_q;

        if (state_q == ST_RUN && tick) begin
            if (count_q != '0) begin
                count_d = count_q - WIDTH'(1);
            end else if (periodic_q) begin
                count_d = load_q;
            end else begin
                state_d = ST_IDLE;
            end
        end

        if (wr_load) begin
            load_d = load_wv[WIDTH-1:0];
        end

        if (wr_ctrl) begin
            periodic_d = ctrl_wv.periodic;
            if (!ctrl_wv.en) begin
                state_d = ST_IDLE;
            end else if (state_q == ST_IDLE) begin
                state_d = ST_RUN;
                count_d = load_q;
            end
        end

        if (wr_count) begin
            count_d = count_wv[WIDTH-1:0];
        end
    end

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            state_q    <= ST_IDLE;
            periodic_q <= 1'b0;
            load_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            periodic_q <= periodic_d;
            load_q     <= load_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: rtl/darktimer_irq.sv
// Multi-channel timer and interrupt-request block for the darkriscv IO space:
// shared prescaler, PEND/MASK, register decode and registered read port.
module darktimer_irq
    import darktimer_pkg::*;
#(
    parameter  int NCH       = 4,
    parameter  int WIDTH     = 32,
    parameter  int PRESC_RST = 99,
    localparam int AW        = $clog2(4*(NCH+1))
) (
    input  logic           CLK,
    input  logic           RES,
    input  logic [AW-1:0]  ADDR,
    input  logic           RD,
    input  logic           WR,
    input  logic [3:0]     BE,
    input  logic [31:0]    DATAI,
    output logic [31:0]    DATAO,
    output logic [NCH-1:0] IRQ,
    output logic           IRQ_ANY
);

    logic [15:0]      presc_q, pcnt_q, presc_wv;
    logic             tick;
    logic [NCH-1:0]   pend_q, mask_q, w1c, ch_fire;
    logic             wr_presc, wr_pend, wr_mask;
    logic [NCH-1:0]   wr_ctrl, wr_load, wr_count;
    ctrl_t            ch_ctrl  [NCH];
    logic [WIDTH-1:0] ch_load  [NCH];
    logic [WIDTH-1:0] ch_count [NCH];
    logic [31:0]      rdata;

    assign wr_presc = WR && (ADDR == AW'(REG_PRESC));
    assign wr_pend  = WR && (ADDR == AW'(REG_PEND));
    assign wr_mask  = WR && (ADDR == AW'(REG_MASK));

    assign tick     = (pcnt_q == '0);
    assign presc_wv = {BE[1] ? DATAI[15:8] : presc_q[15:8],
                       BE[0] ? DATAI[7:0]  : presc_q[7:0]};

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            presc_q <= 16'(PRESC_RST);
            pcnt_q  <= 16'(PRESC_RST);
        end else if (wr_presc) begin
            presc_q <= presc_wv;
            pcnt_q  <= presc_wv;
        end else if (tick) begin
            pcnt_q  <= presc_q;
        end else begin
            pcnt_q  <= pcnt_q - 16'd1;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign wr_ctrl[i]  = WR && (ADDR == AW'(CH_BASE + CH_STRIDE*i + CH_CTRL));
        assign wr_load[i]  = WR && (ADDR == AW'(CH_BASE + CH_STRIDE*i + CH_LOAD));
        assign wr_count[i] = WR && (ADDR == AW'(CH_BASE + CH_STRIDE*i + CH_COUNT));

        darktimer_ch #(.WIDTH(WIDTH)) u_ch (
            .CLK      (CLK),
            .RES      (RES),
            .tick     (tick),
            .wr_ctrl  (wr_ctrl[i]),
            .wr_load  (wr_load[i]),
            .wr_count (wr_count[i]),
            .BE       (BE),
            .DATAI    (DATAI),
            .ctrl     (ch_ctrl[i]),
            .load     (ch_load[i]),
            .count    (ch_count[i]),
            .fire     (ch_fire[i])
        );
    end

    // NCH never exceeds 8, so PEND and MASK live entirely in byte lane 0.
    assign w1c = (wr_pend && BE[0]) ? DATAI[NCH-1:0] : '0;

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            pend_q <= '0;
            mask_q <= '0;
        end else begin
            pend_q <= (pend_q & ~w1c) | ch_fire;
            if (wr_mask && BE[0]) begin
                mask_q <= DATAI[NCH-1:0];
            end
        end
    end

    assign IRQ     = pend_q & mask_q;
    assign IRQ_ANY = |IRQ;

    always_comb begin
        rdata = '0;
        if (ADDR == AW'(REG_INFO)) begin
            rdata = {16'h0, 8'(WIDTH), 8'(NCH)};
        end else if (ADDR == AW'(REG_PRESC)) begin
            rdata[15:0] = presc_q;
        end else if (ADDR == AW'(REG_PEND)) begin
            rdata[NCH-1:0] = pend_q;
        end else if (ADDR == AW'(REG_MASK)) begin
            rdata[NCH-1:0] = mask_q;
        end
        for (int i = 0; i < NCH; i++) begin
            if (ADDR == AW'(CH_BASE + CH_STRIDE*i + CH_CTRL)) begin
                rdata[CTRL_PERIODIC] = ch_ctrl[i].periodic;
                rdata[CTRL_EN]       = ch_ctrl[i].en;
            end else if (ADDR == AW'(CH_BASE + CH_STRIDE*i + CH_LOAD)) begin
                rdata[WIDTH-1:0] = ch_load[i];
            end else if (ADDR == AW'(CH_BASE + CH_STRIDE*i + CH_COUNT)) begin
                rdata[WIDTH-1:0] = ch_count[i];
            end
        end
    end

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            DATAO <= '0;
        end else if (RD) begin
            DATAO <= rdata;
        end
    end

endmodule
